iob_mem_responder: RTL and testbench

IOB_MEM_RESPONDER -- requirements
Module: iob_mem_responder

---
 rtl/iob_mem_responder_pkg.sv | 12 +
 rtl/iob_ram_sp_be.sv | 26 ++
 rtl/iob_mem_responder.sv | 94 +++++++++
 tb/tb_iob_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/iob_mem_responder_pkg.sv
// Shared FSM state encoding and counter width for the IOB memory responder.
package iob_mem_responder_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port synchronous RAM with per-byte write enables and read-first output.
module iob_ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   d,
  output logic [DATA_W-1:0]   q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // q captures the old word, so a same-cycle write is not visible on q.
  always_ff @(posedge clk) begin
    if (en) begin
      q <= mem[addr];
      for (int i = 0; i < DATA_W/8; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= d[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/iob_mem_responder.sv
// IOB memory responder: one outstanding request, fixed wait latency, byte-strobed writes.
module iob_mem_responder
  import iob_mem_responder_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o
);

  localparam int STRB_W = DATA_W/8;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              accept;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] rdata_hold;

  assign accept = (state == ST_IDLE) && iob_avalid_i;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (iob_avalid_i) begin
          cnt_nx   = LAT_CNT;
          state_nx = (LATENCY > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        cnt_nx = (cnt == '0) ? '0 : cnt - CNT_W'(1);
        if (!iob_avalid_i)             state_nx = ST_IDLE;
        else if (cnt <= CNT_W'(1))     state_nx = ST_ACK;
      end
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_hold <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      rvalid_q <= (state == ST_ACK) && (wstrb_q == '0);
      if (accept) begin
        addr_q  <= iob_addr_i;
        wdata_q <= iob_wdata_i;
        wstrb_q <= iob_wstrb_i;
      end
      if (rvalid_q) rdata_hold <= ram_q;
    end
  end

  iob_ram_sp_be #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk  (clk_i),
    .en   (state == ST_ACK),
    .we   (wstrb_q),
    .addr (addr_q),
    .d    (wdata_q),
    .q    (ram_q)
  );

  assign iob_ready_o  = (state == ST_ACK);
  assign iob_rvalid_o = rvalid_q;
  // Read data is shown live from the RAM in the rvalid cycle, held afterwards.
  assign iob_rdata_o  = rvalid_q ? ram_q : rdata_hold;

endmodule

// File: tb/tb_iob_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 0) against a word-array memory model.
module tb_iob_mem_responder;

  localparam int DW = 32;
  localparam int AW = 10;

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } rv_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic          avalid [2];
  logic [AW-1:0] addr   [2];
  logic [DW-1:0] wdata  [2];
  logic [3:0]    wstrb  [2];
  logic          ready  [2];
  logic          rvalid [2];
  logic [DW-1:0] rdata  [2];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] mdl  [2][2**AW];
  logic [DW-1:0] hold [2];
  int  exp_rdy [2][$];
  rv_t exp_rv  [2][$];

  iob_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(2)) dut0 (
    .clk_i(clk), .arst_n_i(rst_n), .iob_avalid_i(avalid[0]), .iob_addr_i(addr[0]),
    .iob_wdata_i(wdata[0]), .iob_wstrb_i(wstrb[0]), .iob_ready_o(ready[0]),
    .iob_rvalid_o(rvalid[0]), .iob_rdata_o(rdata[0]));

  iob_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(0)) dut1 (
    .clk_i(clk), .arst_n_i(rst_n), .iob_avalid_i(avalid[1]), .iob_addr_i(addr[1]),
    .iob_wdata_i(wdata[1]), .iob_wstrb_i(wstrb[1]), .iob_ready_o(ready[1]),
    .iob_rvalid_o(rvalid[1]), .iob_rdata_o(rdata[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents ready or rvalid.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (ready[k]) begin
          if (exp_rdy[k].size() == 0) flag($sformatf("unexpected_ready[%0d]", k));
          else check($sformatf("ready_cycle[%0d]", k), cyc, exp_rdy[k].pop_front());
        end
        if (rvalid[k]) begin
          if (exp_rv[k].size() == 0) flag($sformatf("unexpected_rvalid[%0d]", k));
          else begin
            rv_t e;
            e = exp_rv[k].pop_front();
            check($sformatf("rvalid_cycle[%0d]", k), cyc, e.cyc);
            check($sformatf("rdata[%0d]", k), rdata[k], e.d);
            hold[k] = e.d;
          end
        end else begin
          check($sformatf("rdata_hold[%0d]", k), rdata[k], hold[k]);
        end
      end
    end
  end

  // Issue one request; b2b keeps avalid high straight out of the previous ACK.
  task automatic req(input int k, input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input bit b2b);
    int  samp;
    int  n;
    rv_t e;
    if (!b2b) begin
      avalid[k] = 1'b0;
      @(negedge clk);
    end
    avalid[k] = 1'b1;
    addr[k]   = a;
    wdata[k]  = wd;
    wstrb[k]  = ws;
    samp = cyc + (b2b ? 2 : 1);
    exp_rdy[k].push_back(samp + lat_of(k));
    if (ws == 4'h0) begin
      e.cyc = samp + lat_of(k) + 1;
      e.d   = mdl[k][a];
      exp_rv[k].push_back(e);
    end else begin
      for (int b = 0; b < 4; b++)
        if (ws[b]) mdl[k][a][8*b +: 8] = wd[8*b +: 8];
    end
    if (b2b) @(negedge clk);
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready[k]) break;
      addr[k]  = AW'($urandom);
      wdata[k] = $urandom;
      wstrb[k] = 4'($urandom);
    end
    if (n == 40) flag($sformatf("ready_timeout[%0d]", k));
  endtask

  task automatic release_bus(input int k, input int n);
    avalid[k] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic random_ops(input int k, input int count);
    logic [AW-1:0] a;
    logic [3:0]    ws;
    bit            b2b;
    for (int i = 0; i < 16; i++) req(k, AW'(16 + i), $urandom, 4'hF, 1'b0);
    for (int i = 0; i < count; i++) begin
      a   = AW'(16 + $urandom_range(0, 15));
      ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      b2b = ($urandom_range(0, 2) == 0);
      req(k, a, $urandom, ws, b2b);
    end
    release_bus(k, 3);
  endtask

  logic [1:0] st;

  initial begin
    for (int k = 0; k < 2; k++) begin
      avalid[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0; hold[k] = '0;
    end
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready0", {31'd0, ready[0]}, 32'd0);
    check("reset_rvalid0", {31'd0, rvalid[0]}, 32'd0);
    check("reset_rdata0", rdata[0], 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Full write then read, LATENCY=2 timing
    req(0, 10'd3, 32'h0000_0005, 4'hF, 1'b0);
    req(0, 10'd3, 32'h0, 4'h0, 1'b0);
    // Partial strobes
    req(0, 10'd7, 32'hAABB_CCDD, 4'hF, 1'b0);
    req(0, 10'd7, 32'h1122_3344, 4'b0101, 1'b0);
    req(0, 10'd7, 32'h0, 4'h0, 1'b0);
    // Abort during WAIT leaves addr 2 untouched
    req(0, 10'd2, 32'h1234_5678, 4'hF, 1'b0);
    release_bus(0, 1);
    avalid[0] = 1'b1; addr[0] = 10'd2; wdata[0] = 32'hFFFF_FFFF; wstrb[0] = 4'hF;
    @(negedge clk);
    avalid[0] = 1'b0;
    repeat (3) @(negedge clk);
    req(0, 10'd2, 32'h0, 4'h0, 1'b0);
    // Reset mid-WAIT on a write to addr 9
    req(0, 10'd9, 32'h0909_0909, 4'hF, 1'b0);
    req(0, 10'd9, 32'h0, 4'h0, 1'b0);
    release_bus(0, 1);
    avalid[0] = 1'b1; addr[0] = 10'd9; wdata[0] = 32'hDEAD_BEEF; wstrb[0] = 4'hF;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    st = dut0.state;
    check("rst_ready", {31'd0, ready[0]}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid[0]}, 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_state", {30'd0, st}, 32'd0);
    check("rst_cnt", {28'd0, dut0.cnt}, 32'd0);
    hold[0] = '0;
    hold[1] = '0;
    avalid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req(0, 10'd9, 32'h0, 4'h0, 1'b0);
    // Four reads with avalid held high throughout
    req(0, 10'd3, 32'h0, 4'h0, 1'b0);
    req(0, 10'd7, 32'h0, 4'h0, 1'b1);
    req(0, 10'd2, 32'h0, 4'h0, 1'b1);
    req(0, 10'd9, 32'h0, 4'h0, 1'b1);
    release_bus(0, 3);

    // LATENCY=0 sequential write/read pairs
    for (int i = 0; i < 10; i++) begin
      req(1, AW'(i), 32'(i), 4'hF, 1'b0);
      req(1, AW'(i), 32'h0, 4'h0, 1'b0);
    end
    release_bus(1, 3);

    random_ops(0, 60);
    random_ops(1, 60);

    repeat (6) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("pending_ready[%0d]", k), 32'(exp_rdy[k].size()), 32'd0);
      check($sformatf("pending_rvalid[%0d]", k), 32'(exp_rv[k].size()), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
